// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the 2-way, 8-set, 32-byte-line
// write-back cache. Decodes CPU requests against the tag/valid/dirty
// state reported by the datapath, drives every array load strobe and
// runs the physical-memory handshake for dirty write-back and refill.
//
// Optional feature macro: CACHE_PERF_CNT_EN
//   defined   -> adds hit_count / miss_count / wb_count outputs
//   undefined -> counters and ports absent, FSM behaviour identical
module cache_control #(
  parameter int s_index = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp,
  input  logic hit_0,
  input  logic hit_1,
  input  logic dirty,
  input  logic LRU,
  output logic load_valid,
  output logic load_tag,
  output logic load_dirty,
  output logic load_lru,
  output logic load_data,
  output logic load_mode,
  output logic dirty_types,
  output logic cache_array_read,
  output logic pmem_addr_mux_sel,
  output logic way_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COMPARE   = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] ALLOCATE  = 3'd3;
  localparam logic [2:0] REFILL    = 3'd4;

  localparam int unsigned SETS = 2 ** s_index;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       victim;
  logic       latch_victim;
  logic       req;
  logic       hit;

  assign req = mem_read | mem_write;
  assign hit = hit_0 | hit_1;

  // State register and victim-way latch; victim is captured on the miss decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state <= next_state;
      if (latch_victim)
        victim <= LRU;
    end
  end

  // Next-state and strobe decode; strobes are Moore from state, gated by
  // hit/dirty in COMPARE and by pmem_resp in ALLOCATE
  always_comb begin
    next_state        = state;
    latch_victim      = 1'b0;
    mem_resp          = 1'b0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    load_valid        = 1'b0;
    load_tag          = 1'b0;
    load_dirty        = 1'b0;
    load_lru          = 1'b0;
    load_data         = 1'b0;
    load_mode         = 1'b0;
    dirty_types       = 1'b0;
    cache_array_read  = 1'b1;
    pmem_addr_mux_sel = 1'b0;
    way_sel           = victim;
    case (state)
      IDLE: begin
        if (req)
          next_state = COMPARE;
      end
      COMPARE: begin
        if (!req) begin
          next_state = IDLE;
        end else if (hit) begin
          // way 0 wins a double hit; a simultaneous read+write is a write
          way_sel  = hit_1 & ~hit_0;
          mem_resp = 1'b1;
          load_lru = 1'b1;
          if (mem_write) begin
            load_data   = 1'b1;
            load_dirty  = 1'b1;
            dirty_types = 1'b1;
          end
          next_state = IDLE;
        end else begin
          // steer the dirty lookup at the eviction candidate
          way_sel      = LRU;
          latch_victim = 1'b1;
          next_state   = dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_addr_mux_sel = 1'b1;
        pmem_write        = 1'b1;
        if (pmem_resp)
          next_state = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data   = 1'b1;
          load_mode   = 1'b1;
          load_tag    = 1'b1;
          load_valid  = 1'b1;
          load_dirty  = 1'b1;
          next_state  = REFILL;
        end
      end
      REFILL: begin
        // arrays are re-read here so the following COMPARE sees the new line
        next_state = COMPARE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic post_refill;
  logic hit_event;
  logic miss_event;
  logic wb_event;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // the COMPARE that follows a refill completes a miss, not a hit
  assign hit_event  = (state == COMPARE) & req & hit & ~post_refill;
  assign miss_event = (state == COMPARE) & req & ~hit;
  assign wb_event   = (state == WRITEBACK) & pmem_resp;

  // Saturating performance counters plus post-refill marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_refill <= 1'b0;
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
      wb_count    <= 32'd0;
    end else begin
      if (state == REFILL)
        post_refill <= 1'b1;
      else if (state == COMPARE)
        post_refill <= 1'b0;
      if (hit_event)
        hit_count <= sat_inc(hit_count);
      if (miss_event)
        miss_count <= sat_inc(miss_count);
      if (wb_event)
        wb_count <= sat_inc(wb_count);
    end
  end
`endif

  // The two pmem requests are mutually exclusive; set count bound sanity
  assert property (@(posedge clk) disable iff (!rst_n)
    !(pmem_read && pmem_write) && (SETS >= 2));

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed bench for cache_control. The bench plays
// the datapath (hit/dirty/LRU) and physical memory (pmem_resp) by hand
// and checks the full strobe vector at each step.
module tb_cache_control;

  logic clk;
  logic rst_n;
  logic mem_read, mem_write, pmem_resp;
  logic hit_0, hit_1, dirty, LRU;
  logic mem_resp, pmem_read, pmem_write;
  logic load_valid, load_tag, load_dirty, load_lru, load_data, load_mode;
  logic dirty_types, cache_array_read, pmem_addr_mux_sel, way_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int errors = 0;
  int checks = 0;

  // strobe vector bit positions
  localparam logic [12:0] RESP = 13'h1000;
  localparam logic [12:0] PRD  = 13'h0800;
  localparam logic [12:0] PWR  = 13'h0400;
  localparam logic [12:0] LV   = 13'h0200;
  localparam logic [12:0] LT   = 13'h0100;
  localparam logic [12:0] LD   = 13'h0080;
  localparam logic [12:0] LL   = 13'h0040;
  localparam logic [12:0] LDA  = 13'h0020;
  localparam logic [12:0] LM   = 13'h0010;
  localparam logic [12:0] DT   = 13'h0008;
  localparam logic [12:0] AR   = 13'h0004;
  localparam logic [12:0] MX   = 13'h0002;
  localparam logic [12:0] WS   = 13'h0001;

  localparam logic [12:0] REFILL_WR = PRD | LDA | LM | LT | LV | LD | AR;
  localparam logic [12:0] WRITE_HIT = RESP | LDA | LD | DT | LL | AR;

  logic [12:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, load_valid, load_tag,
                 load_dirty, load_lru, load_data, load_mode, dirty_types,
                 cache_array_read, pmem_addr_mux_sel, way_sel};

  cache_control #(.s_index(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .hit_0(hit_0),
    .hit_1(hit_1),
    .dirty(dirty),
    .LRU(LRU),
    .load_valid(load_valid),
    .load_tag(load_tag),
    .load_dirty(load_dirty),
    .load_lru(load_lru),
    .load_data(load_data),
    .load_mode(load_mode),
    .dirty_types(dirty_types),
    .cache_array_read(cache_array_read),
    .pmem_addr_mux_sel(pmem_addr_mux_sel),
    .way_sel(way_sel)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count),
    .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] exp);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", tag, outs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit_0 = 1'b0; hit_1 = 1'b0; dirty = 1'b0; LRU = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset", AR);
    @(negedge clk); rst_n = 1'b1; #1 chk("post_reset_idle", AR);

    // reset in the middle of a write-back
    @(negedge clk); mem_read = 1'b1; #1 chk("a_idle_req", AR);
    @(negedge clk); dirty = 1'b1; LRU = 1'b1; #1 chk("a_cmp_dirty_miss", AR | WS);
    @(negedge clk); #1 chk("a_wb", PWR | MX | AR | WS);
    #2 rst_n = 1'b0;
    #1 chk("a_rst_drop", AR);
    @(negedge clk); mem_read = 1'b0; dirty = 1'b0; LRU = 1'b0; #1 chk("a_in_reset", AR);
    @(negedge clk); rst_n = 1'b1; #1 chk("a_idle", AR);
    @(negedge clk); #1 chk("a_no_resp", AR);

    // cold read 0x40: clean miss into way 0
    @(negedge clk); mem_read = 1'b1; #1 chk("b_idle", AR);
    @(negedge clk); #1 chk("b_cmp_miss", AR);
    @(negedge clk); #1 chk("b_alloc", PRD | AR);
    @(negedge clk); #1 chk("b_alloc_wait", PRD | AR);
    @(negedge clk); pmem_resp = 1'b1; #1 chk("b_alloc_resp", REFILL_WR);
    @(negedge clk); pmem_resp = 1'b0; #1 chk("b_refill", AR);
    @(negedge clk); hit_0 = 1'b1; #1 chk("b_cmp_hit", RESP | LL | AR);
    @(negedge clk); mem_read = 1'b0; hit_0 = 1'b0; #1 chk("b_idle_after", AR);

    // repeat read 0x40: hit way 0
    @(negedge clk); mem_read = 1'b1; #1 chk("c_idle", AR);
    @(negedge clk); hit_0 = 1'b1; #1 chk("c_read_hit", RESP | LL | AR);
    @(negedge clk); mem_read = 1'b0; hit_0 = 1'b0; #1 chk("c_idle_after", AR);

    // write hit 0x44
    @(negedge clk); mem_write = 1'b1; #1 chk("d_idle", AR);
    @(negedge clk); hit_0 = 1'b1; #1 chk("d_write_hit", WRITE_HIT);
    @(negedge clk); mem_write = 1'b0; hit_0 = 1'b0; #1 chk("d_idle_after", AR);

    // request withdrawn before COMPARE: no strobes even with a hit
    @(negedge clk); mem_read = 1'b1; #1 chk("e0_idle", AR);
    @(negedge clk); mem_read = 1'b0; hit_0 = 1'b1; #1 chk("e0_cmp_noreq", AR);
    @(negedge clk); hit_0 = 1'b0; pmem_resp = 1'b1; #1 chk("e0_idle_presp_ignored", AR);
    @(negedge clk); pmem_resp = 1'b0; #1 chk("e0_idle_stays", AR);

    // fill way 1 of set 2 (clean miss, LRU=1)
    @(negedge clk); mem_read = 1'b1; #1 chk("e1_idle", AR);
    @(negedge clk); LRU = 1'b1; #1 chk("e1_cmp_miss", AR | WS);
    @(negedge clk); LRU = 1'b0; #1 chk("e1_alloc", PRD | AR | WS);
    @(negedge clk); pmem_resp = 1'b1; #1 chk("e1_alloc_resp", REFILL_WR | WS);
    @(negedge clk); pmem_resp = 1'b0; #1 chk("e1_refill", AR | WS);
    @(negedge clk); hit_1 = 1'b1; #1 chk("e1_cmp_hit", RESP | LL | AR | WS);
    @(negedge clk); mem_read = 1'b0; hit_1 = 1'b0; #1 chk("e1_idle_victim", AR | WS);

    // write hit way 1 makes it dirty
    @(negedge clk); mem_write = 1'b1; #1 chk("e2_idle", AR | WS);
    @(negedge clk); hit_1 = 1'b1; #1 chk("e2_write_hit_w1", WRITE_HIT | WS);
    @(negedge clk); mem_write = 1'b0; hit_1 = 1'b0; #1 chk("e2_idle_after", AR | WS);

    // new tag to set 2, dirty LRU way 1: write-back then refill
    @(negedge clk); mem_read = 1'b1; #1 chk("e3_idle", AR | WS);
    @(negedge clk); LRU = 1'b1; dirty = 1'b1; #1 chk("e3_cmp_dirty_miss", AR | WS);
    @(negedge clk); LRU = 1'b0; dirty = 1'b0; #1 chk("e3_wb", PWR | MX | AR | WS);
    @(negedge clk); #1 chk("e3_wb_wait", PWR | MX | AR | WS);
    @(negedge clk); pmem_resp = 1'b1; #1 chk("e3_wb_resp", PWR | MX | AR | WS);
    @(negedge clk); pmem_resp = 1'b0; #1 chk("e3_alloc", PRD | AR | WS);
    @(negedge clk); pmem_resp = 1'b1; #1 chk("e3_alloc_resp", REFILL_WR | WS);
    @(negedge clk); pmem_resp = 1'b0; #1 chk("e3_refill", AR | WS);
    @(negedge clk); hit_1 = 1'b1; #1 chk("e3_cmp_hit", RESP | LL | AR | WS);
    @(negedge clk); mem_read = 1'b0; hit_1 = 1'b0; #1 chk("e3_idle_after", AR | WS);

    // read and write together on a double hit: write to way 0, one response
    @(negedge clk); mem_read = 1'b1; mem_write = 1'b1; #1 chk("f_idle", AR | WS);
    @(negedge clk); hit_0 = 1'b1; hit_1 = 1'b1; #1 chk("f_rw_double_hit", WRITE_HIT);
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b0; hit_0 = 1'b0; hit_1 = 1'b0;
    #1 chk("f_idle_after", AR | WS);
    @(negedge clk); #1 chk("f_single_resp", AR | WS);

`ifdef CACHE_PERF_CNT_EN
    chk32("hit_count", hit_count, 32'd4);
    chk32("miss_count", miss_count, 32'd3);
    chk32("wb_count", wb_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
